// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared constants and types for the register-file read-port arbiter.
//   REG_W / REG_ADDR_W / NUM_REGS describe the 32 x 32-bit register file.
//   ZERO_REG is the hard-wired zero register: reads of it always return 0.
package regfile_arb_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_word_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

  function automatic logic is_zero_reg(input reg_addr_t a);
    return (a == ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The requester at index ptr has the
//   highest priority, then ptr+1, ... wrapping modulo NREQ.
//   Ports:
//     req   [NREQ-1:0]  in   request vector
//     ptr   [PTR_W-1:0] in   index of the highest-priority requester
//     grant [NREQ-1:0]  out  one-hot grant, zero when req is zero
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  // Rotate the request vector so bit 0 is the requester at ptr, isolate the
  // lowest set bit, then rotate back. The doubled vectors make the rotations
  // plain shifts.
  logic [2*NREQ-1:0] w_req_dbl;
  logic [2*NREQ-1:0] w_req_shr;
  logic [NREQ-1:0]   w_req_rot;
  logic [NREQ-1:0]   w_pick_rot;
  logic [2*NREQ-1:0] w_pick_dbl;
  logic [2*NREQ-1:0] w_pick_shl;

  assign w_req_dbl  = {req, req};
  assign w_req_shr  = w_req_dbl >> ptr;
  assign w_req_rot  = w_req_shr[NREQ-1:0];
  assign w_pick_rot = w_req_rot & (~w_req_rot + NREQ'(1));
  assign w_pick_dbl = {w_pick_rot, w_pick_rot};
  assign w_pick_shl = w_pick_dbl << ptr;
  assign grant      = w_pick_shl[2*NREQ-1:NREQ];

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Shares the single register-file read port between NREQ requesters.
//   Stage A grants one requester per cycle (round robin), stage S holds the
//   registered read select, stage R holds the captured word and owner ID.
//   A request accepted in cycle t is presented on rd_sel during t+1 and its
//   response is valid in t+2.
//   Optional feature macro: RFARB_WR_BYPASS_EN -- when defined, a write to
//   the register being read in stage S is forwarded into the response.
//   Ports:
//     clk, reset              clock, asynchronous active-high reset
//     req_valid/req_ready     per-requester handshake (req_ready one-hot/zero)
//     req_addr                per-requester register number
//     rd_sel / rd_data        shared read-mux select and returned word
//     wr_en/wr_addr/wr_data   register-file write port (bypass source)
//     resp_valid/resp_ready   response handshake
//     resp_id / resp_data     owner requester and read result
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  reg_addr_t [NREQ-1:0]  req_addr,
  output logic [NREQ-1:0]       req_ready,
  output reg_addr_t             rd_sel,
  input  reg_word_t             rd_data,
  input  logic                  wr_en,
  input  reg_addr_t             wr_addr,
  input  reg_word_t             wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output reg_word_t             resp_data
);

  logic [ID_W-1:0] r_ptr;
  reg_addr_t       r_rd_sel_p1;
  logic            r_vld_p1;
  logic [ID_W-1:0] r_id_p1;
  logic            r_vld_p2;
  logic [ID_W-1:0] r_id_p2;
  reg_word_t       r_data_p2;

  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_gid;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            w_stall;
  logic            w_hs;
  reg_word_t       w_cap;

  // Stage A: combinational arbitration
  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // A full S entry that cannot drain into a blocked R freezes the pipeline.
  assign w_stall   = r_vld_p2 & ~resp_ready & r_vld_p1;
  assign req_ready = (reset || w_stall) ? '0 : w_grant;
  assign w_hs      = ~reset & ~w_stall & (|w_grant);

  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gid = ID_W'(i);
    end
  end

  assign w_ptr_nxt = (w_gid == ID_W'(NREQ - 1)) ? '0 : w_gid + ID_W'(1);

  // Word captured at the end of stage S. It is re-evaluated every cycle an
  // entry is held, so the value taken when S finally advances reflects the
  // latest write.
  always_comb begin
    w_cap = rd_data;
`ifdef RFARB_WR_BYPASS_EN
    if (wr_en && (wr_addr == r_rd_sel_p1)) w_cap = wr_data;
`endif
    if (is_zero_reg(r_rd_sel_p1)) w_cap = '0;
  end

`ifndef RFARB_WR_BYPASS_EN
  logic w_unused_wr;
  assign w_unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_rd_sel_p1 <= '0;
      r_vld_p1    <= 1'b0;
      r_id_p1     <= '0;
      r_vld_p2    <= 1'b0;
      r_id_p2     <= '0;
      r_data_p2   <= '0;
    end else if (!w_stall) begin
      // Stage S: registered select and owner
      if (w_hs) begin
        r_vld_p1    <= 1'b1;
        r_rd_sel_p1 <= req_addr[w_gid];
        r_id_p1     <= w_gid;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_vld_p1    <= 1'b0;
      end
      // Stage R: response registers
      if (r_vld_p1) begin
        r_vld_p2  <= 1'b1;
        r_id_p2   <= r_id_p1;
        r_data_p2 <= w_cap;
      end else if (resp_ready) begin
        r_vld_p2  <= 1'b0;
      end
    end
  end

  assign rd_sel     = r_rd_sel_p1;
  assign resp_valid = r_vld_p2;
  assign resp_id    = r_id_p2;
  assign resp_data  = r_data_p2;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter
//   Directed bench for regfile_read_arbiter (NREQ=4). A small register-file
//   model supplies rd_data for rd_sel and applies writes on the clock edge.
module tb_regfile_read_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][4:0] req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [4:0]           rd_sel;
  logic [31:0]          rd_data;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [31:0]          wr_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [31:0]          resp_data;

  logic [31:0] regs [32];
  logic [31:0] exp_byp;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_sel];

  regfile_read_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the register-file model writes on the same edge.
  task automatic step();
    @(posedge clk);
    if (wr_en) regs[wr_addr] <= wr_data;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hC000_0000 | 32'(i);
    regs[5]  = 32'h0000_0010;
    regs[7]  = 32'hAAAA_AAAA;
    regs[31] = 32'hFFFF_FFFF;
`ifdef RFARB_WR_BYPASS_EN
    exp_byp = 32'h1234_5678;
`else
    exp_byp = 32'hAAAA_AAAA;
`endif

    // Reset with all requesters pending
    reset = 1'b1; req_valid = 4'b1111; resp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < NREQ; i++) req_addr[i] = 5'(i + 1);
    step(); step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rvalid", 32'(resp_valid), 32'h0);
    chk("rst_rdsel", 32'(rd_sel), 32'h0);
    chk("rst_rid", 32'(resp_id), 32'h0);
    chk("rst_rdata", resp_data, 32'h0);

    // Round robin: 8 accepting cycles, then drain
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = 4'b0000;
      #1;
      chk("rr_ready", 32'(req_ready), (k < 8) ? (32'(1) << (k % 4)) : 32'h0);
      if (k >= 1 && k <= 8) chk("rr_rdsel", 32'(rd_sel), 32'((k - 1) % 4 + 1));
      if (k >= 2) begin
        chk("rr_rvalid", 32'(resp_valid), 32'h1);
        chk("rr_rid", 32'(resp_id), 32'((k - 2) % 4));
        chk("rr_rdata", resp_data, 32'hC000_0000 | 32'((k - 2) % 4 + 1));
      end
      step();
    end
    chk("rr_drained", 32'(resp_valid), 32'h0);

    // Single read: requester 2, register 5 (ptr = 0)
    req_valid = 4'b0100; req_addr[2] = 5'd5; #1;
    chk("one_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000; #1;
    chk("one_rdsel", 32'(rd_sel), 32'd5);
    chk("one_rvalid_t1", 32'(resp_valid), 32'h0);
    step();
    chk("one_rvalid", 32'(resp_valid), 32'h1);
    chk("one_rid", 32'(resp_id), 32'd2);
    chk("one_rdata", resp_data, 32'h0000_0010);
    step();
    chk("one_done", 32'(resp_valid), 32'h0);

    // Backpressure: requesters 0 and 1, consumer blocked (ptr = 3)
    req_addr[0] = 5'd8; req_addr[1] = 5'd9;
    req_valid = 4'b0011; resp_ready = 1'b0; #1;
    chk("bp_ready_a", 32'(req_ready), 32'h1);
    step();
    chk("bp_ready_b", 32'(req_ready), 32'h2);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready_hold", 32'(req_ready), 32'h0);
      chk("bp_rdsel_hold", 32'(rd_sel), 32'd9);
      chk("bp_rvalid_hold", 32'(resp_valid), 32'h1);
      chk("bp_rid_hold", 32'(resp_id), 32'd0);
      chk("bp_rdata_hold", resp_data, 32'hC000_0008);
      step();
    end
    req_valid = 4'b0000; resp_ready = 1'b1; #1;
    chk("bp_rel_rvalid0", 32'(resp_valid), 32'h1);
    chk("bp_rel_rid0", 32'(resp_id), 32'd0);
    chk("bp_rel_rdata0", resp_data, 32'hC000_0008);
    step();
    chk("bp_rel_rvalid1", 32'(resp_valid), 32'h1);
    chk("bp_rel_rid1", 32'(resp_id), 32'd1);
    chk("bp_rel_rdata1", resp_data, 32'hC000_0009);
    step();
    chk("bp_rel_empty", 32'(resp_valid), 32'h0);

    // Zero register: requester 3 reads 31 (ptr = 2)
    req_addr[3] = 5'd31; req_valid = 4'b1000; #1;
    chk("zr_ready", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0000; #1;
    chk("zr_rdsel", 32'(rd_sel), 32'd31);
    step();
    chk("zr_rvalid", 32'(resp_valid), 32'h1);
    chk("zr_rid", 32'(resp_id), 32'd3);
    chk("zr_rdata", resp_data, 32'h0);
    step();

    // Write to the register while it is in stage S (ptr = 0)
    req_addr[0] = 5'd7; req_valid = 4'b0001; #1;
    chk("byp_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; #1;
    chk("byp_rdsel", 32'(rd_sel), 32'd7);
    step();
    wr_en = 1'b0; #1;
    chk("byp_rvalid", 32'(resp_valid), 32'h1);
    chk("byp_rid", 32'(resp_id), 32'd0);
    chk("byp_rdata", resp_data, exp_byp);
    step();

    // Reset with an entry in flight (ptr = 1)
    req_addr[1] = 5'd2; req_valid = 4'b0010; #1;
    chk("mr_ready", 32'(req_ready), 32'h2);
    step();
    reset = 1'b1; #1;
    chk("mr_ready_rst", 32'(req_ready), 32'h0);
    chk("mr_rdsel_rst", 32'(rd_sel), 32'h0);
    chk("mr_rvalid_rst", 32'(resp_valid), 32'h0);
    step();
    reset = 1'b0; req_valid = 4'b0000;
    step();
    chk("mr_no_resp", 32'(resp_valid), 32'h0);
    req_valid = 4'b0110; #1;
    chk("mr_ptr_restart", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    step();
    chk("mr_rvalid", 32'(resp_valid), 32'h1);
    chk("mr_rid", 32'(resp_id), 32'd1);
    chk("mr_rdata", resp_data, 32'hC000_0002);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the single 32-register read port (the 32×32-bit word mux driven by a 5-bit select) between `NREQ` requesters, e.g. the fetch/decode operand reads and the debug read path. Each requester presents a register address with a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order, drives the read-port select from a register, and captures the selected word. It returns the word with the requester's ID two cycles after acceptance, with optional write-to-read bypass.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester ID, equal to `$clog2(NREQ)`.

Ports:
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-high.
- `req_valid` in, `NREQ`: request pending, one bit per requester.
- `req_addr` in, `NREQ`×5: register number requested, per requester.
- `req_ready` out, `NREQ`: grant, one-hot or zero; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `rd_sel` out, 5: select driven into the shared read mux.
- `rd_data` in, 32: word returned combinationally by the read mux for `rd_sel`.
- `wr_en` in, 1: register-file write strobe, same cycle as the write.
- `wr_addr` in, 5: register-file write address.
- `wr_data` in, 32: register-file write data.
- `resp_valid` out, 1: response available.
- `resp_ready` in, 1: consumer accepts the response.
- `resp_id` out, `ID_W`: index of the requester that owns the response.
- `resp_data` out, 32: read result.

## Operation
- Pipeline stages:
  - A (arbitrate): combinational grant.
  - S (select): registered `rd_sel`, `s_valid`, `s_id`.
  - R (response): registered `resp_*`.
- Grant rule: the highest-priority requester with `req_valid` set wins. Priority starts at pointer `ptr` and wraps upward modulo `NREQ`.
- After a handshake by requester `g`: `ptr <= (g+1) mod NREQ`. With no handshake, `ptr` holds.
- Starvation bound: a continuously asserted request is granted within `NREQ` accepting cycles.
- Stall:
  - The pipeline stalls when `resp_valid & ~resp_ready` and S is occupied.
  - During a stall, `req_ready` = 0, S holds (`rd_sel` stable), R holds, and `ptr` holds.
- No stall otherwise:
  - A handshake loads S with `s_valid=1`, `rd_sel=req_addr[g]`, `s_id=g`.
  - With no handshake, S loads `s_valid=0` and keeps `rd_sel` unchanged.
  - If `s_valid` is set, R loads `resp_valid=1`, `resp_id=s_id`, and `resp_data` = captured word.
  - If `s_valid` is clear and `resp_ready` is high, `resp_valid` is cleared.
- Register 31 is the zero register. A read of 31 always returns 0, regardless of `rd_data` and bypass.
- `req_ready` is low for all requesters whenever `reset` is high.

## Timing
- Reset values:
  - `req_ready=0`, `rd_sel=0`, `resp_valid=0`, `resp_id=0`, `resp_data=0`.
  - Internal state: `s_valid=0`, `s_id=0`, `ptr=0`.
- Reset mid-operation discards any in-flight S/R entries with no response. The pointer restarts at 0.
- Latency:
  - Handshake in cycle t.
  - `rd_sel` is valid throughout t+1, and `rd_data` is sampled at the end of t+1.
  - `resp_valid` is asserted in t+2.
- Throughput: one request per cycle when `resp_ready` is held high.
- `resp_*` are stable while `resp_valid & ~resp_ready`.
- Handshake and response retire in the same cycle: allowed, with no bubble.

## Configuration
- Macro: `RFARB_WR_BYPASS_EN`.
- When defined:
  - In stage S, if `s_valid & wr_en & (wr_addr==rd_sel) & (rd_sel!=31)`, capture `wr_data` instead of `rd_data`.
  - The same check is applied to a held S entry during a stall, so the latest write wins.
- When undefined:
  - `wr_en`, `wr_addr` and `wr_data` are ignored (ports remain).
  - `rd_data` is always captured. Write-after-read ordering is then the register file's responsibility.

## Structure
- Package `regfile_arb_pkg` holds:
  - Constants `REG_W=32`, `REG_ADDR_W=5`, `NUM_REGS=32`, `ZERO_REG=5'd31`.
  - Typedefs `reg_addr_t` (logic [4:0]) and `reg_word_t` (logic [31:0]).
- Sub-module `rr_arbiter`:
  - Parameterised by `NREQ`.
  - Inputs `req`, `ptr`; output is the one-hot `grant`, computed combinationally.
  - The pointer register lives in the top module.

## Test plan
- Reset check: assert `reset` with `req_valid=4'b1111` -> `req_ready=0`, `resp_valid=0`, `rd_sel=0`. Then release reset -> first grant goes to requester 0.
- Single read: requester 2 reads address 5, `rd_data` model returns 0x0000_0010 -> `resp_valid` in cycle t+2 with `resp_id=2`, `resp_data=0x10`.
- Round-robin fairness: all four requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and responses return in the same order.
- Backpressure: hold `resp_ready=0` for 3 cycles with requesters 0 and 1 valid -> `req_ready=0` and all outputs stable. Then raise `resp_ready` -> no response is lost or duplicated.
- Zero register: read address 31 with `rd_data=0xFFFF_FFFF` -> `resp_data=0`.
- Bypass: read address 7 with `rd_data=0xAAAA_AAAA`, and in cycle t+1 `wr_en=1`, `wr_addr=7`, `wr_data=0x1234_5678` -> `resp_data=0x1234_5678` with the macro defined, `0xAAAA_AAAA` without it.
